map_writer: RTL and testbench

- Write-side engine for the 256x256-tile background colour memory that the display path reads at {y[9:2], x[9:2]}.
- Accepts rectangle-fill commands in tile coordinates through a valid/ready handshake.
- Sweeps the rectangle in raster order, driving one memory write per cycle on the background RAM write port (address/data/wren).
- Used to paint or clear regions of the background at runtime.

---
 rtl/map_writer_if.sv | 35 +++
 rtl/map_writer.sv | 116 +++++++++++
 tb/tb_map_writer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/map_writer_if.sv
`default_nettype none
// ============================================================================
// map_writer_if : command handshake and background-RAM write port bundle
// Rev 1.0
// ============================================================================
interface map_writer_if #(
  parameter int TILE_W  = 8,
  parameter int COLOR_W = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [TILE_W-1:0]     cmd_x0;
  logic [TILE_W-1:0]     cmd_y0;
  logic [TILE_W-1:0]     cmd_x1;
  logic [TILE_W-1:0]     cmd_y1;
  logic [COLOR_W-1:0]    cmd_color;
  logic [2*TILE_W-1:0]   mem_address;
  logic [COLOR_W-1:0]    mem_data;
  logic                  mem_wren;
  logic                  busy;
  logic                  done;

  // Command issuer side.
  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready, mem_address, mem_data, mem_wren, busy, done
  );

  // Fill engine side.
  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready, mem_address, mem_data, mem_wren, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/map_writer.sv
`default_nettype none
// ============================================================================
// map_writer : rectangle-fill engine writing the background tile colour map
// Rev 1.0
// ============================================================================
module map_writer #(
  parameter int TILE_W  = 8,
  parameter int COLOR_W = 12
) (
  input  logic         clock,
  input  logic         resetn,
  map_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [TILE_W-1:0]    r_cx;
  logic [TILE_W-1:0]    r_cy;
  logic [TILE_W-1:0]    r_xmin;
  logic [TILE_W-1:0]    r_xmax;
  logic [TILE_W-1:0]    r_ymax;
  logic [COLOR_W-1:0]   r_color;
  logic                 r_wren;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ready;

  logic [TILE_W-1:0]    w_xmin;
  logic [TILE_W-1:0]    w_xmax;
  logic [TILE_W-1:0]    w_ymin;
  logic [TILE_W-1:0]    w_ymax;
  logic                 w_last;

  // Corners may arrive in any order; normalise at accept time.
  assign w_xmin = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x0 : bus.cmd_x1;
  assign w_xmax = (bus.cmd_x0 < bus.cmd_x1) ? bus.cmd_x1 : bus.cmd_x0;
  assign w_ymin = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y0 : bus.cmd_y1;
  assign w_ymax = (bus.cmd_y0 < bus.cmd_y1) ? bus.cmd_y1 : bus.cmd_y0;

  // Equality termination keeps rectangles touching tile 255 from wrapping.
  assign w_last = (r_cx == r_xmax) && (r_cy == r_ymax);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymax  <= '0;
      r_color <= '0;
      r_wren  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.cmd_valid && r_ready) begin
            r_xmin  <= w_xmin;
            r_xmax  <= w_xmax;
            r_ymax  <= w_ymax;
            r_cx    <= w_xmin;
            r_cy    <= w_ymin;
            r_color <= bus.cmd_color;
            r_wren  <= 1'b1;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_last) begin
            r_wren  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cx != r_xmax) begin
            r_cx <= r_cx + 1'b1;
          end else begin
            r_cx <= r_xmin;
            r_cy <= r_cy + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_wren  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Counters double as the write address and hold after the fill ends.
  assign bus.mem_address = {r_cy, r_cx};
  assign bus.mem_data    = r_color;
  assign bus.mem_wren    = r_wren;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.cmd_ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_map_writer.sv
`default_nettype none
// ============================================================================
// tb_map_writer : directed self-checking bench for the map_writer fill engine
// Rev 1.0
// ============================================================================
module tb_map_writer;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  // Committed writes as {address, data}.
  logic [27:0] wlog[$];

  map_writer_if #(.TILE_W(8), .COLOR_W(12)) bus ();

  map_writer #(.TILE_W(8), .COLOR_W(12)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.mem_wren === 1'b1) wlog.push_back({bus.mem_address, bus.mem_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [7:0] x0, input logic [7:0] y0,
                     input logic [7:0] x1, input logic [7:0] y1,
                     input logic [11:0] color);
    bus.cmd_x0    = x0;
    bus.cmd_y0    = y0;
    bus.cmd_x1    = x1;
    bus.cmd_y1    = y1;
    bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
  endtask

  logic [15:0] swap_exp [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    swap_exp = '{16'h0101, 16'h0102, 16'h0103, 16'h0201, 16'h0202, 16'h0203};
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
    bus.cmd_color = '0;

    // Reset held for three cycles.
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_wren",  bus.mem_wren,    1'b0);
    chk("rst_busy",  bus.busy,        1'b0);
    chk("rst_done",  bus.done,        1'b0);
    chk("rst_ready", bus.cmd_ready,   1'b1);
    chk("rst_addr",  bus.mem_address, 16'h0000);
    chk("rst_data",  bus.mem_data,    12'h000);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", bus.cmd_ready, 1'b1);
    chk("post_rst_wren",  bus.mem_wren,  1'b0);

    // Single tile.
    wlog.delete();
    cmd(8'd5, 8'd7, 8'd5, 8'd7, 12'hF00);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    chk("one_wren",  bus.mem_wren,    1'b1);
    chk("one_addr",  bus.mem_address, 16'h0705);
    chk("one_data",  bus.mem_data,    12'hF00);
    chk("one_busy",  bus.busy,        1'b1);
    chk("one_ready", bus.cmd_ready,   1'b0);
    @(negedge clock);
    chk("one_done",       bus.done,      1'b1);
    chk("one_done_wren",  bus.mem_wren,  1'b0);
    chk("one_done_busy",  bus.busy,      1'b0);
    chk("one_done_ready", bus.cmd_ready, 1'b0);
    @(negedge clock);
    chk("one_idle_done",  bus.done,        1'b0);
    chk("one_idle_ready", bus.cmd_ready,   1'b1);
    chk("one_hold_addr",  bus.mem_address, 16'h0705);
    chk("one_hold_data",  bus.mem_data,    12'hF00);
    chk("one_count",      wlog.size(),     1);

    // Swapped corners: raster order from (1,1) to (3,2).
    wlog.delete();
    cmd(8'd3, 8'd2, 8'd1, 8'd1, 12'h0F0);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("swap_wren%0d", i), bus.mem_wren,    1'b1);
      chk($sformatf("swap_addr%0d", i), bus.mem_address, swap_exp[i]);
      @(negedge clock);
    end
    chk("swap_done",  bus.done,     1'b1);
    chk("swap_wren",  bus.mem_wren, 1'b0);
    chk("swap_count", wlog.size(),  6);
    chk("swap_data",  wlog[5][11:0], 12'h0F0);
    @(negedge clock);

    // Rectangle ending at the top tile must not wrap to 0x0000.
    wlog.delete();
    cmd(8'd254, 8'd255, 8'd255, 8'd255, 12'h00F);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    chk("edge_addr0", bus.mem_address, 16'hFFFE);
    @(negedge clock);
    chk("edge_addr1", bus.mem_address, 16'hFFFF);
    chk("edge_wren1", bus.mem_wren,    1'b1);
    @(negedge clock);
    chk("edge_done",  bus.done,     1'b1);
    chk("edge_wren",  bus.mem_wren, 1'b0);
    repeat (3) @(negedge clock);
    chk("edge_count", wlog.size(),  2);
    chk("edge_last",  wlog[wlog.size()-1][27:12], 16'hFFFF);
    chk("edge_idle",  bus.mem_wren, 1'b0);

    // Back-pressure: second command held valid through the first fill.
    wlog.delete();
    cmd(8'd0, 8'd0, 8'd1, 8'd0, 12'h00F);
    @(negedge clock);
    cmd(8'd10, 8'd10, 8'd10, 8'd10, 12'hABC);
    chk("bp_a_addr0",  bus.mem_address, 16'h0000);
    chk("bp_a_ready0", bus.cmd_ready,   1'b0);
    @(negedge clock);
    chk("bp_a_addr1",  bus.mem_address, 16'h0001);
    chk("bp_a_data1",  bus.mem_data,    12'h00F);
    chk("bp_a_ready1", bus.cmd_ready,   1'b0);
    @(negedge clock);
    chk("bp_done",       bus.done,      1'b1);
    chk("bp_done_ready", bus.cmd_ready, 1'b0);
    @(negedge clock);
    chk("bp_idle_ready", bus.cmd_ready, 1'b1);
    chk("bp_idle_wren",  bus.mem_wren,  1'b0);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    chk("bp_b_wren", bus.mem_wren,    1'b1);
    chk("bp_b_addr", bus.mem_address, 16'h0A0A);
    chk("bp_b_data", bus.mem_data,    12'hABC);
    @(negedge clock);
    chk("bp_b_done",  bus.done,    1'b1);
    chk("bp_count",   wlog.size(), 3);
    @(negedge clock);

    // Mid-fill reset on a full-map fill after 100 committed writes.
    wlog.delete();
    cmd(8'd0, 8'd0, 8'd255, 8'd255, 12'h555);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 300 && wlog.size() < 100; i++) @(negedge clock);
    chk("mid_reach100", wlog.size(), 100);
    resetn = 1'b0;
    #1;
    chk("mid_async_wren", bus.mem_wren, 1'b0);
    chk("mid_async_busy", bus.busy,     1'b0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    chk("mid_count",  wlog.size(),   100);
    chk("mid_last",   wlog[99][27:12], 16'h0063);
    chk("mid_wren",   bus.mem_wren,  1'b0);
    chk("mid_ready",  bus.cmd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
